// File: rtl/fib_seq_if.sv
// Start/done handshake bundle for the runtime Fibonacci/Lucas sequence engine.
interface fib_seq_if #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 6
);
  logic               start;
  logic [N_WIDTH-1:0] n;
  logic               mode;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               overflow;

  modport master (
    output start, n, mode,
    input  busy, done, result, overflow
  );

  modport slave (
    input  start, n, mode,
    output busy, done, result, overflow
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Iterative Fibonacci / Lucas term generator: one step per clock, sticky overflow tag on the
// term pair so that only a genuine wrap of term n reaches the overflow output.
//
// state | meaning
// IDLE  | waiting for start; result/overflow hold the last completed term
// CALC  | stepping the (a, b) pair until cnt reaches zero, then publishing a
module fib_seq_engine #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 6
) (
  input  logic     clk,
  input  logic     rst,
  fib_seq_if.slave bus
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a, b;
  logic               ova, ovb;
  logic [N_WIDTH-1:0] cnt;
  logic               busy_q, done_q, overflow_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH:0]     sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      ova        <= 1'b0;
      ovb        <= 1'b0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a      <= bus.mode ? WIDTH'(2) : '0;
            b      <= WIDTH'(1);
            ova    <= 1'b0;
            ovb    <= 1'b0;
            cnt    <= bus.n;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            a   <= b;
            b   <= sum[WIDTH-1:0];
            // b leads a by one term, so its wrap only becomes visible once it shifts into a
            ova <= ovb;
            ovb <= ova | ovb | sum[WIDTH];
            cnt <= cnt - 1'b1;
          end else begin
            result_q   <= a;
            overflow_q <= ova;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule
